mem_b_sequencer: RTL and testbench
==================================

MEM_B_SEQUENCER -- requirements
Module: mem_b_sequencer

Interface
REQ-001 The block SHALL have the following parameters:
- DATA_W, 32, word width of memory B.
- ADDR_W, 5, address width of memory B.
- DEPTH, 32, number of words in memory B.

REQ-002 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- mode  in  1  operation select, sampled with start: 0 = LOAD, 1 = DUMP.
- len  in  ADDR_W+1  word count, sampled with start.
- s_valid  in  1  input stream valid.
- s_data  in  DATA_W  input stream word.
- s_ready  out  1  input stream ready.
- m_valid  out  1  output stream valid.
- m_data  out  DATA_W  output stream word.
- m_ready  in  1  output stream ready.
- busy  out  1  high while in LOAD, DUMP or DRAIN.
- done  out  1  one-cycle pulse when an operation completes.
- ena_B  out  1  memory B enable.
- wea_B  out  1  memory B write enable.
- addra_B  out  ADDR_W  memory B address.
- dina_B  out  DATA_W  memory B write data.
- douta_B  in  DATA_W  memory B read data.

REQ-003 One clock and an asynchronous, active-high reset SHALL be used; the ports SHALL be named clk and rst.

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, DUMP and DRAIN.
- IDLE goes to LOAD when start=1 and mode=0.
- IDLE goes to DUMP when start=1 and mode=1.
- LOAD goes to IDLE when the last write is accepted.
- DUMP goes to DRAIN when the last read is issued.
- DRAIN goes to IDLE when the last word is accepted on the output.
REQ-005 On entry to LOAD or DUMP, the block SHALL set the word count N to len, with len > DEPTH clamped to DEPTH.
REQ-006 When len=0, the block SHALL stay in IDLE, pulse done on the next cycle and perform no memory access.
REQ-007 The block SHALL ignore start outside IDLE.
REQ-008 In LOAD, s_ready SHALL be 1; each cycle with s_valid=1 SHALL drive ena_B=1, wea_B=1, dina_B=s_data and addra_B equal to the index of that word (0 .. N-1), all in the same cycle.
REQ-009 Outside LOAD, s_ready SHALL be 0.
REQ-010 In DUMP, the block SHALL issue reads with ena_B=1, wea_B=0 at addresses 0 .. N-1 in order.
REQ-011 douta_B SHALL be treated as valid exactly one cycle after the read is issued, and the word SHALL be captured into a 2-entry output FIFO.
REQ-012 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 2, so that the FIFO never overflows under any m_ready pattern.
REQ-013 m_valid SHALL be high whenever the FIFO is non-empty; m_data SHALL be the FIFO head.
REQ-014 A word SHALL be popped from the FIFO when m_valid=1 and m_ready=1.
REQ-015 A push and a pop in the same cycle SHALL be legal and SHALL leave the occupancy unchanged.
REQ-016 With m_ready held at 1, DUMP SHALL sustain one word per cycle; the first m_valid SHALL appear 2 cycles after the start cycle.
REQ-017 Once the output stream has presented m_valid=1, m_valid and m_data SHALL hold stable until the word is accepted.
REQ-018 The address counter SHALL count 0 .. N-1 and SHALL never wrap; for N=DEPTH the last address is DEPTH-1.
REQ-019 When memory B is not being accessed, ena_B and wea_B SHALL be 0.
REQ-020 done SHALL pulse for exactly one cycle: in the cycle after the last LOAD write, or in the cycle after the last DUMP word is accepted.
REQ-021 done and start on the same cycle SHALL be legal: the new start is accepted because the FSM is already in IDLE.

Reset
REQ-022 While rst=1, the block SHALL hold the FSM in IDLE, clear the counters, empty the FIFO and discard in-flight reads.
REQ-023 While rst=1, the outputs SHALL be: s_ready=0, m_valid=0, m_data=0, busy=0, done=0, ena_B=0, wea_B=0, addra_B=0, dina_B=0.
REQ-024 Reset asserted mid-LOAD or mid-DUMP SHALL abort the operation with no done pulse; memory contents already written are left as they are.

Verification
REQ-025 The bench SHALL cover at least the following directed scenarios:
- LOAD, len=4, s_valid held high with words 0xA0..0xA3 -> 4 writes to addresses 0..3, no idle cycles between them; done pulses one cycle after the last write.
- DUMP, len=4 after the load above, m_ready=1 -> m_data = 0xA0..0xA3 on consecutive cycles, the first 2 cycles after start; done follows the last handshake.
- DUMP, len=32, m_ready toggling 1,0,0,1 -> all 32 words delivered in order with none lost or duplicated; FIFO occupancy never exceeds 2; the last read address is 31.
- len=0 -> done pulses one cycle after start; ena_B stays 0; busy stays 0.
- len=40 -> clamped to 32; address 31 is the last access.
- rst asserted at word 10 of a DUMP with len=32 -> all outputs return to their reset values immediately with no done pulse; a new start afterwards operates normally.

Source files
------------

// File: rtl/mem_b_sequencer.sv
// Sequences bulk transfers between a valid/ready stream and memory B:
// LOAD writes N stream words to addresses 0..N-1, DUMP reads them back out.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | writing one word per accepted s_valid beat
// DUMP  | issuing reads into the 2-deep output FIFO
// DRAIN | all reads issued, emptying the FIFO
module mem_b_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W:0]   len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              ena_B,
    output logic              wea_B,
    output logic [ADDR_W-1:0] addra_B,
    output logic [DATA_W-1:0] dina_B,
    input  logic [DATA_W-1:0] douta_B
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W:0]     r_n, r_cnt;
    logic                r_done, r_pend;
    logic [DATA_W-1:0]   r_fifo [2];
    logic                r_wr_ptr, r_rd_ptr;
    logic [1:0]          r_occ;

    logic [ADDR_W:0]     w_len_clamp;
    logic                w_write, w_read, w_last, w_pop, w_fifo_pop, w_push, w_done_nxt;
    logic [1:0]          w_outst;

    assign w_len_clamp = (len > DEPTH_V) ? DEPTH_V : len;
    assign w_last      = (r_cnt == r_n - ONE);
    assign w_outst     = r_occ + {1'b0, r_pend};
    assign w_write     = (r_state == S_LOAD) && s_valid;
    assign w_read      = (r_state == S_DUMP) && (w_outst < 2'd2);
    assign w_pop       = m_valid && m_ready;
    assign w_fifo_pop  = w_pop && (r_occ != 2'd0);
    // A word arriving from memory while the FIFO is empty can be taken
    // straight from douta_B; it is only stored if it is not accepted.
    assign w_push      = r_pend && !(w_pop && (r_occ == 2'd0));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        s_ready     = (r_state == S_LOAD);
        busy        = (r_state != S_IDLE);
        done        = r_done;
        ena_B       = w_write || w_read;
        wea_B       = w_write;
        addra_B     = '0;
        dina_B      = '0;
        m_valid     = (r_occ != 2'd0) || r_pend;
        m_data      = '0;
        if (ena_B) addra_B = r_cnt[ADDR_W-1:0];
        if (w_write) dina_B = s_data;
        if (r_occ != 2'd0) m_data = r_fifo[r_rd_ptr];
        else if (r_pend) m_data = douta_B;
        case (r_state)
            S_IDLE: begin
                if (start && len != '0) w_state_nxt = mode ? S_DUMP : S_LOAD;
                if (start && len == '0) w_done_nxt = 1'b1;
            end
            S_LOAD: begin
                if (w_write && w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DUMP: begin
                if (w_read && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && w_outst == 2'd1) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_pend    <= 1'b0;
            r_n       <= '0;
            r_cnt     <= '0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_pend  <= w_read;
            if (r_state == S_IDLE && start) begin
                r_n   <= w_len_clamp;
                r_cnt <= '0;
            end else if (w_write || w_read) begin
                r_cnt <= w_last ? '0 : r_cnt + ONE;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= douta_B;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_fifo_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_b_sequencer.sv
// Self-checking bench for mem_b_sequencer: directed LOAD/DUMP scenarios plus
// randomized operations checked against an expected-contents array.
module tb_mem_b_sequencer;

    logic        clk, rst, start, mode;
    logic [5:0]  len;
    logic        s_valid, s_ready, m_valid, m_ready, busy, done, ena_B, wea_B;
    logic [31:0] s_data, m_data, dina_B, douta_B;
    logic [4:0]  addra_B;

    logic [31:0] mem_b   [32];
    logic [31:0] ref_mem [32];
    int n_vec = 0;
    int n_err = 0;

    mem_b_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .done(done), .ena_B(ena_B), .wea_B(wea_B),
        .addra_B(addra_B), .dina_B(dina_B), .douta_B(douta_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory B: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (ena_B) begin
            if (wea_B) mem_b[addra_B] <= dina_B;
            else       douta_B <= mem_b[addra_B];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"},  m_data, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_ena"},     ena_B, 0);
        check({tag, "_wea"},     wea_B, 0);
        check({tag, "_addr"},    addra_B, 0);
        check({tag, "_din"},     dina_B, 0);
    endtask

    task automatic op_len0(input bit md);
        @(posedge clk); #1;
        start = 1; mode = md; len = 0;
        @(negedge clk);
        check("z_start_busy", busy, 0);
        check("z_start_ena", ena_B, 0);
        check("z_start_done", done, 0);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_ena", ena_B, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("z_done_low", done, 0);
        check("z_busy_after", busy, 0);
    endtask

    task automatic op_load(input int len_v, input bit rnd);
        int n, idx, cyc;
        bit v;
        logic [31:0] d;
        n = (len_v > 32) ? 32 : len_v;
        @(posedge clk); #1;
        start = 1; mode = 0; len = len_v[5:0]; s_valid = 0;
        @(negedge clk);
        check("ld_start_busy", busy, 0);
        @(posedge clk); #1;
        start = 0;
        idx = 0; cyc = 0;
        while (idx < n && cyc < 400) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = rnd ? $urandom : 32'hA0 + idx;
            s_valid = v; s_data = d;
            @(negedge clk);
            check("ld_s_ready", s_ready, 1);
            check("ld_busy", busy, 1);
            check("ld_done_low", done, 0);
            check("ld_ena", ena_B, v);
            check("ld_wea", wea_B, v);
            if (v) begin
                check("ld_addr", addra_B, idx);
                check("ld_din", dina_B, d);
                ref_mem[idx] = d;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 0;
        check("ld_words", idx, n);
        @(negedge clk);
        check("ld_done", done, 1);
        check("ld_busy_end", busy, 0);
        check("ld_s_ready_end", s_ready, 0);
        check("ld_ena_end", ena_B, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ld_done_once", done, 0);
    endtask

    // rpat: 0 = m_ready held 1, 1 = repeating 1,0,0,1, 2 = random
    task automatic op_dump(input int len_v, input int rpat, input int abort_at);
        int n, k, r, cyc, last_addr;
        bit rdy, prev_hold;
        logic [31:0] prev_data;
        n = (len_v > 32) ? 32 : len_v;
        @(posedge clk); #1;
        start = 1; mode = 1; len = len_v[5:0]; m_ready = 0;
        @(negedge clk);
        check("dp_start_busy", busy, 0);
        check("dp_start_valid", m_valid, 0);
        @(posedge clk); #1;
        start = 0;
        k = 0; r = 0; cyc = 1; last_addr = -1; prev_hold = 0; prev_data = 0;
        while (k < n && cyc < 600) begin
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1;
                #1;
                check_reset_outputs("ab");
                @(negedge clk);
                check("ab_done_low", done, 0);
                @(posedge clk); #1;
                rst = 0; m_ready = 0;
                @(negedge clk);
                check("ab_done_after", done, 0);
                check("ab_busy_after", busy, 0);
                return;
            end
            case (rpat)
                0:       rdy = 1'b1;
                1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            m_ready = rdy;
            @(negedge clk);
            check("dp_s_ready", s_ready, 0);
            check("dp_busy", busy, 1);
            check("dp_done_low", done, 0);
            if (prev_hold) begin
                check("dp_hold_valid", m_valid, 1);
                check("dp_hold_data", m_data, prev_data);
            end
            if (ena_B) begin
                check("dp_wea", wea_B, 0);
                check("dp_rd_addr", addra_B, r);
                last_addr = int'(addra_B);
                r++;
            end
            check("dp_outstanding", ((r - k) <= 2), 1);
            if (rpat == 0) check("dp_valid_stream", m_valid, (cyc >= 2));
            if (m_valid && rdy) begin
                check("dp_data", m_data, ref_mem[k]);
                k++;
            end
            prev_hold = m_valid && !rdy;
            prev_data = m_data;
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 0;
        check("dp_words", k, n);
        check("dp_reads", r, n);
        check("dp_last_addr", last_addr, n - 1);
        @(negedge clk);
        check("dp_done", done, 1);
        check("dp_busy_end", busy, 0);
        check("dp_valid_end", m_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("dp_done_once", done, 0);
    endtask

    initial begin
        int l;
        rst = 1; start = 0; mode = 0; len = 0;
        s_valid = 0; s_data = 0; m_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 0;

        op_load(4, 0);
        op_dump(4, 0, -1);
        op_len0(0);
        op_len0(1);
        op_load(40, 1);
        op_dump(32, 1, -1);
        op_dump(40, 0, -1);
        op_dump(32, 0, 10);
        op_dump(32, 2, -1);

        for (int i = 0; i < 12; i++) begin
            l = $urandom_range(0, 40);
            if (l == 0)                     op_len0($urandom_range(0, 1) != 0);
            else if ($urandom_range(0, 1)) op_load(l, 1);
            else                            op_dump(l, 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
